// File: rtl/toy_bus_arb_pkg.sv
// Shared definitions for the toy bus arbiter nodes.
// Holds the default payload layout (field widths and bit offsets), the
// per-channel payload widths, and the lock state type used by the arbiters.
package toy_bus_arb_pkg;

    // Payload fields, packed from LSB upward: tgt_id, src_id, sideband, data, opcode.
    localparam int OPC_W  = 1;
    localparam int DATA_W = 256;
    localparam int SB_W   = 32;
    localparam int SRC_W  = 4;
    localparam int TGT_W  = 4;

    localparam int PLD_W_DEF = OPC_W + DATA_W + SB_W + SRC_W + TGT_W;

    localparam int TGT_LSB  = 0;
    localparam int SRC_LSB  = TGT_LSB + TGT_W;
    localparam int SB_LSB   = SRC_LSB + SRC_W;
    localparam int DATA_LSB = SB_LSB + SB_W;
    localparam int OPC_LSB  = DATA_LSB + DATA_W;

    // Per-channel payload widths; the ack channel carries no data beat.
    localparam int REQ_PLD_W = PLD_W_DEF;
    localparam int DAT_PLD_W = PLD_W_DEF;
    localparam int ACK_PLD_W = OPC_W + SB_W + SRC_W + TGT_W;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/toy_bus_age_mtx.sv
// Age matrix for a WIDTH-input least-recently-granted arbiter.
// rows[i][j]=1 means input j is older than input i (i yields to j).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   upd        : apply an update this cycle
//   upd_oh     : one-hot index of the input that just became youngest
//   rows       : current matrix rows; diagonal always reads 0
module toy_bus_age_mtx #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         upd,
    input  logic [WIDTH-1:0]             upd_oh,
    output logic [WIDTH-1:0][WIDTH-1:0]  rows
);

    logic [WIDTH-1:0][WIDTH-1:0] age_q, age_d;

    // Granted row goes to all-ones (youngest), its column clears elsewhere.
    // The diagonal is held at 0 so selection needs no masking.
    always_comb begin
        age_d = age_q;
        if (upd) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (i != j) begin
                        if (upd_oh[i])      age_d[i][j] = 1'b1;
                        else if (upd_oh[j]) age_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++)
                for (int j = 0; j < WIDTH; j++)
                    age_q[i][j] <= (j < i);
        end else begin
            age_q <= age_d;
        end
    end

    assign rows = age_q;

endmodule

// File: rtl/toy_bus_age_arb_nway.sv
// N-input age-matrix (least-recently-granted) valid/ready arbiter with
// optional multi-beat packet locking and optional registered output stage.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_vld/in_rdy         : per-input handshake
//   in_pld                : input i payload at [i*PLD_W +: PLD_W]
//   in_last               : last beat of packet (lock release)
//   out_vld/out_rdy       : output handshake
//   out_pld/out_last      : selected payload / last
//   out_grant             : one-hot source of the current output beat
module toy_bus_age_arb_nway
    import toy_bus_arb_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int PLD_W   = PLD_W_DEF,
    parameter bit LOCK_EN = 1'b1,
    parameter bit FORWARD = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_vld,
    output logic [N_IN-1:0]         in_rdy,
    input  logic [N_IN*PLD_W-1:0]   in_pld,
    input  logic [N_IN-1:0]         in_last,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [PLD_W-1:0]        out_pld,
    output logic                    out_last,
    output logic [N_IN-1:0]         out_grant
);

    logic [N_IN-1:0][N_IN-1:0] age;
    logic [N_IN-1:0]           arb_sel, grant;
    logic [N_IN-1:0]           lock_oh_q, lock_oh_d;
    lock_state_e               lock_q, lock_d;
    logic                      take, accept, upd, sel_last;
    logic [PLD_W-1:0]          sel_pld;

    toy_bus_age_mtx #(.WIDTH(N_IN)) u_mtx (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd    (upd),
        .upd_oh (grant),
        .rows   (age)
    );

    // An input wins when no valid input is older than it.
    always_comb begin
        for (int i = 0; i < N_IN; i++)
            arb_sel[i] = in_vld[i] & ~|(age[i] & in_vld);
    end

    // While locked only the owner can be granted; if it drops vld nobody is.
    assign grant = (lock_q == ARB_LOCKED) ? (lock_oh_q & in_vld) : arb_sel;

    always_comb begin
        sel_pld  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            sel_pld  = sel_pld | (in_pld[i*PLD_W +: PLD_W] & {PLD_W{grant[i]}});
            sel_last = sel_last | (in_last[i] & grant[i]);
        end
    end

    assign in_rdy = grant & {N_IN{take}};
    assign accept = |grant & take;

    // Lock tracking; the matrix only ages on packet boundaries when locking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q    <= ARB_OPEN;
            lock_oh_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_oh_q <= lock_oh_d;
        end
    end

    always_comb begin
        lock_d    = lock_q;
        lock_oh_d = lock_oh_q;
        upd       = 1'b0;
        if (accept) begin
            if (!LOCK_EN || sel_last) begin
                upd    = 1'b1;
                lock_d = ARB_OPEN;
            end else begin
                lock_d    = ARB_LOCKED;
                lock_oh_d = grant;
            end
        end
    end

    if (FORWARD) begin : g_fwd
        // Stage is held closed during reset; afterwards it takes a beat
        // whenever it is empty or draining this cycle.
        assign take = rst_n & (~out_vld | out_rdy);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_vld   <= 1'b0;
                out_pld   <= '0;
                out_last  <= 1'b0;
                out_grant <= '0;
            end else if (accept) begin
                out_vld   <= 1'b1;
                out_pld   <= sel_pld;
                out_last  <= sel_last;
                out_grant <= grant;
            end else if (out_rdy) begin
                out_vld   <= 1'b0;
            end
        end
    end else begin : g_comb
        assign take      = out_rdy;
        assign out_vld   = |grant;
        assign out_pld   = sel_pld;
        assign out_last  = sel_last;
        assign out_grant = grant;
    end

endmodule

// File: tb/tb_toy_bus_age_arb_nway.sv
// Bench for toy_bus_age_arb_nway: a 4-input locked/registered instance and a
// 2-input unlocked/combinational instance, each checked against an LRU-list
// reference model (oldest first, granted input moves to the tail).
module tb_toy_bus_age_arb_nway;

    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: N_IN=4, LOCK_EN=1, FORWARD=1
    logic            rst_a;
    logic [3:0]      vld_a, rdy_a, last_a, ogrant_a;
    logic [4*PW-1:0] pld_a;
    logic            ovld_a, ordy_a, olast_a;
    logic [PW-1:0]   opld_a;

    toy_bus_age_arb_nway #(.N_IN(4), .PLD_W(PW), .LOCK_EN(1'b1), .FORWARD(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a), .in_vld(vld_a), .in_rdy(rdy_a), .in_pld(pld_a),
        .in_last(last_a), .out_vld(ovld_a), .out_rdy(ordy_a), .out_pld(opld_a),
        .out_last(olast_a), .out_grant(ogrant_a)
    );

    // Instance B: N_IN=2, LOCK_EN=0, FORWARD=0
    logic            rst_b;
    logic [1:0]      vld_b, rdy_b, last_b, ogrant_b;
    logic [2*PW-1:0] pld_b;
    logic            ovld_b, ordy_b, olast_b;
    logic [PW-1:0]   opld_b;

    toy_bus_age_arb_nway #(.N_IN(2), .PLD_W(PW), .LOCK_EN(1'b0), .FORWARD(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b), .in_vld(vld_b), .in_rdy(rdy_b), .in_pld(pld_b),
        .in_last(last_b), .out_vld(ovld_b), .out_rdy(ordy_b), .out_pld(opld_b),
        .out_last(olast_b), .out_grant(ogrant_b)
    );

    // Reference model state
    int            ord_a[4];
    bit            lk;
    int            lk_idx;
    bit            m_ov, m_olast;
    logic [PW-1:0] m_opld;
    logic [3:0]    m_ogrant;
    int            ord_b[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void move_end_a(input int g);
        int k = 0;
        while (ord_a[k] != g) k++;
        for (int m = k; m < 3; m++) ord_a[m] = ord_a[m+1];
        ord_a[3] = g;
    endfunction

    function automatic void move_end_b(input int g);
        if (ord_b[0] == g) begin
            ord_b[0] = ord_b[1];
            ord_b[1] = g;
        end
    endfunction

    function automatic void reset_a();
        for (int k = 0; k < 4; k++) ord_a[k] = k;
        lk = 0; lk_idx = 0; m_ov = 0; m_olast = 0; m_opld = '0; m_ogrant = '0;
    endfunction

    // One clock of instance A: drive, check mid-cycle, advance the model at the edge.
    task automatic cyc_a(input logic [3:0] v, input logic [3:0] l, input logic ordy, input logic rst);
        int            g;
        logic          st_free;
        logic [3:0]    e_rdy;
        logic [PW-1:0] p[4];
        vld_a = v; last_a = l; ordy_a = ordy; rst_a = rst;
        for (int i = 0; i < 4; i++) begin
            p[i] = PW'($urandom);
            pld_a[i*PW +: PW] = p[i];
        end
        g = -1;
        if (lk) begin
            if (v[lk_idx]) g = lk_idx;
        end else begin
            for (int k = 0; k < 4; k++)
                if (g < 0 && v[ord_a[k]]) g = ord_a[k];
        end
        st_free = !m_ov || ordy;
        e_rdy = (rst && st_free && g >= 0) ? 4'(1 << g) : 4'b0;
        #4;
        chk("a_in_rdy", 64'(rdy_a), 64'(e_rdy));
        chk("a_out_vld", 64'(ovld_a), 64'(m_ov));
        chk("a_out_pld", 64'(opld_a), 64'(m_opld));
        chk("a_out_last", 64'(olast_a), 64'(m_olast));
        chk("a_out_grant", 64'(ogrant_a), 64'(m_ogrant));
        @(posedge clk);
        if (!rst) begin
            reset_a();
        end else if (e_rdy != 4'b0) begin
            m_ov = 1; m_opld = p[g]; m_olast = l[g]; m_ogrant = 4'(1 << g);
            if (l[g]) begin
                lk = 0;
                move_end_a(g);
            end else begin
                lk = 1;
                lk_idx = g;
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        #1;
    endtask

    // One clock of instance B (fully combinational outputs).
    task automatic cyc_b(input logic [1:0] v, input logic [1:0] l, input logic ordy, input logic rst);
        int            g;
        logic [PW-1:0] p[2];
        logic [1:0]    e_rdy;
        vld_b = v; last_b = l; ordy_b = ordy; rst_b = rst;
        for (int i = 0; i < 2; i++) begin
            p[i] = PW'($urandom);
            pld_b[i*PW +: PW] = p[i];
        end
        g = -1;
        for (int k = 0; k < 2; k++)
            if (g < 0 && v[ord_b[k]]) g = ord_b[k];
        e_rdy = (ordy && g >= 0) ? 2'(1 << g) : 2'b0;
        #4;
        chk("b_in_rdy", 64'(rdy_b), 64'(e_rdy));
        chk("b_out_vld", 64'(ovld_b), 64'(g >= 0));
        chk("b_out_pld", 64'(opld_b), (g >= 0) ? 64'(p[g]) : 64'(0));
        chk("b_out_last", 64'(olast_b), (g >= 0) ? 64'(l[g]) : 64'(0));
        chk("b_out_grant", 64'(ogrant_b), (g >= 0) ? 64'(1 << g) : 64'(0));
        @(posedge clk);
        if (!rst) begin
            ord_b[0] = 0; ord_b[1] = 1;
        end else if (e_rdy != 2'b0) begin
            move_end_b(g);
        end
        #1;
    endtask

    initial begin
        rst_a = 0; vld_a = '0; last_a = '0; pld_a = '0; ordy_a = 1;
        rst_b = 0; vld_b = '0; last_b = '0; pld_b = '0; ordy_b = 1;
        @(posedge clk);
        #1;
        reset_a();
        ord_b[0] = 0; ord_b[1] = 1;

        // Reset state, in_rdy held low while in reset
        cyc_a(4'b1111, 4'b1111, 1, 0);
        cyc_a(4'b0000, 4'b0000, 1, 1);

        // All four valid, single-beat: round robin by age, 1-cycle latency
        repeat (7) cyc_a(4'b1111, 4'b1111, 1, 1);

        // Fresh reset, then input 2 holds a 3-beat packet against the others
        cyc_a(4'b0000, 4'b0000, 1, 0);
        cyc_a(4'b0100, 4'b0000, 1, 1);
        cyc_a(4'b1111, 4'b0000, 1, 1);
        cyc_a(4'b1111, 4'b0100, 1, 1);
        repeat (3) cyc_a(4'b1111, 4'b1111, 1, 1);

        // Locked input 1 drops vld for two cycles mid-packet
        cyc_a(4'b0010, 4'b0000, 1, 1);
        repeat (2) cyc_a(4'b1101, 4'b1111, 1, 1);
        cyc_a(4'b1111, 4'b0000, 1, 1);
        cyc_a(4'b1111, 4'b0010, 1, 1);
        repeat (2) cyc_a(4'b1111, 4'b1111, 1, 1);

        // Output back-pressure with the stage full
        cyc_a(4'b1111, 4'b1111, 1, 1);
        repeat (5) cyc_a(4'b1111, 4'b1111, 0, 1);
        repeat (5) cyc_a(4'b1111, 4'b1111, 1, 1);

        // Reset in the middle of a packet from input 3
        cyc_a(4'b1000, 4'b0000, 1, 1);
        cyc_a(4'b1111, 4'b0000, 1, 1);
        cyc_a(4'b1111, 4'b1111, 1, 0);
        repeat (3) cyc_a(4'b1111, 4'b1111, 1, 1);

        // Random traffic on the locked/registered instance
        repeat (400) cyc_a(4'($urandom), 4'($urandom | $urandom), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 60) != 0);

        // Two-input combinational instance: alternating then contending valids
        cyc_b(2'b11, 2'b00, 1, 0);
        cyc_b(2'b01, 2'b01, 1, 1);
        cyc_b(2'b10, 2'b10, 1, 1);
        cyc_b(2'b01, 2'b00, 1, 1);
        cyc_b(2'b10, 2'b11, 0, 1);
        cyc_b(2'b10, 2'b11, 1, 1);
        repeat (4) cyc_b(2'b11, 2'($urandom), 1, 1);
        cyc_b(2'b11, 2'b00, 0, 1);
        cyc_b(2'b11, 2'b00, 1, 1);
        repeat (300) cyc_b(2'($urandom), 2'($urandom), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 60) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
